// File: rtl/decoder_3to8_pulse_if.sv
// Encoded-select bus between a code source and the 3-to-8 pulse decoder.
// The source drives enable/code/code_valid; the decoder returns ready and the strobe outputs.
interface decoder_3to8_pulse_if;
   logic       enable;
   logic [2:0] code;
   logic       code_valid;
   logic       code_ready;
   logic [7:0] y;
   logic       busy;
   logic       done;
   logic       abort;

   modport master (
      output enable, code, code_valid,
      input  code_ready, y, busy, done, abort
   );

   modport slave (
      input  enable, code, code_valid,
      output code_ready, y, busy, done, abort
   );
endinterface

// File: rtl/decoder_3to8_pulse.sv
// Sequential 3-to-8 decoder: each accepted code becomes a registered one-hot strobe
// of PULSE_LEN cycles, followed by GAP_LEN quiet cycles before the next accept.
module decoder_3to8_pulse #(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   decoder_3to8_pulse_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } state_t;

   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
   localparam logic [7:0] GAP_LOAD   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

   state_t     state_reg, state_next;
   logic [7:0] count_reg, count_next;
   logic [7:0] y_reg, y_next;
   logic       busy_reg, busy_next;
   logic       done_reg, done_next;
   logic       abort_reg, abort_next;

   assign bus.code_ready = bus.enable && (state_reg == IDLE);
   assign bus.y          = y_reg;
   assign bus.busy       = busy_reg;
   assign bus.done       = done_reg;
   assign bus.abort      = abort_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         count_reg <= 8'd0;
         y_reg     <= 8'd0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         abort_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         y_reg     <= y_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         abort_reg <= abort_next;
      end
   end

   // One down-counter is shared by the strobe and the gap; abort beats normal completion.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      y_next     = y_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      abort_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.code_valid && bus.code_ready) begin
               state_next = ACTIVE;
               y_next     = 8'b1 << bus.code;
               busy_next  = 1'b1;
               count_next = PULSE_LOAD;
            end
         end
         ACTIVE: begin
            if (!bus.enable) begin
               state_next = IDLE;
               y_next     = 8'd0;
               busy_next  = 1'b0;
               abort_next = 1'b1;
               count_next = 8'd0;
            end else if (count_reg == 8'd0) begin
               y_next    = 8'd0;
               done_next = 1'b1;
               if (GAP_LEN > 0) begin
                  state_next = GAP;
                  count_next = GAP_LOAD;
               end else begin
                  state_next = IDLE;
                  busy_next  = 1'b0;
               end
            end else begin
               count_next = count_reg - 8'd1;
            end
         end
         GAP: begin
            if (!bus.enable) begin
               state_next = IDLE;
               busy_next  = 1'b0;
               abort_next = 1'b1;
               count_next = 8'd0;
            end else if (count_reg == 8'd0) begin
               state_next = IDLE;
               busy_next  = 1'b0;
            end else begin
               count_next = count_reg - 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            y_next     = 8'd0;
            busy_next  = 1'b0;
            count_next = 8'd0;
         end
      endcase
   end

endmodule
